// File: rtl/bp_be_dcache_pkg.sv
// rtl/bp_be_dcache_pkg.sv - shared replay-queue entry type and issue-pointer ops
`ifndef BP_BE_DCACHE_PKG_SV
`define BP_BE_DCACHE_PKG_SV

// Replay-queue entry: uncached-store flag above the payload, sized by the user.
`define BP_BE_REPLAY_ENTRY_S(width) \
   typedef struct packed { \
      logic             uc_store; \
      logic [width-1:0] payload; \
   } bp_be_replay_entry_s

package bp_be_dcache_pkg;

   // How the issue pointer moves on the next edge.
   typedef enum logic [1:0] {
      e_rptr_hold   = 2'd0,
      e_rptr_inc    = 2'd1,
      e_rptr_rewind = 2'd2
   } bp_be_rptr_op_e;

endpackage

`endif

// File: rtl/bp_be_replay_credit_counter.sv
// rtl/bp_be_replay_credit_counter.sv - outstanding uncached-store credit counter
module bp_be_replay_credit_counter #(
   parameter int max_credits_p = 4
) (
   input  logic clk_i,
   input  logic reset_n_i,
   input  logic inc_i,
   input  logic dec_i,
   output logic full_o,
   output logic empty_o,
   output logic underflow_o
);

   localparam int cnt_width_lp = $clog2(max_credits_p + 1);
   localparam logic [cnt_width_lp-1:0] max_cnt_lp = cnt_width_lp'(max_credits_p);

   logic [cnt_width_lp-1:0] cnt_q, cnt_d;

   assign full_o  = (cnt_q == max_cnt_lp);
   assign empty_o = (cnt_q == '0);

   // Simultaneous issue and return cancel; a lone return at zero is flagged, not applied.
   always_comb begin
      cnt_d       = cnt_q;
      underflow_o = 1'b0;
      if (inc_i && !dec_i) begin
         if (!full_o) cnt_d = cnt_q + cnt_width_lp'(1);
      end else if (dec_i && !inc_i) begin
         if (empty_o) underflow_o = 1'b1;
         else         cnt_d = cnt_q - cnt_width_lp'(1);
      end
   end

   // Counter register.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) cnt_q <= '0;
      else            cnt_q <= cnt_d;
   end

endmodule

// File: rtl/bp_be_dcache_replay_queue.sv
// rtl/bp_be_dcache_replay_queue.sv - checkpoint/rollback issue queue with uc-store credits
module bp_be_dcache_replay_queue
   import bp_be_dcache_pkg::*;
#(
   parameter int width_p       = 64,
   parameter int els_p         = 8,
   parameter int max_credits_p = 4,
   localparam int ptr_width_lp = $clog2(els_p) + 1
) (
   input  logic                    clk_i,
   input  logic                    reset_n_i,
   input  logic [width_p-1:0]      data_i,
   input  logic                    uc_store_i,
   input  logic                    v_i,
   output logic                    ready_o,
   output logic [width_p-1:0]      data_o,
   output logic                    v_o,
   input  logic                    yumi_i,
   input  logic                    ckpt_v_i,
   input  logic                    roll_v_i,
   input  logic                    clr_v_i,
   input  logic                    credit_return_i,
   output logic [ptr_width_lp-1:0] count_o,
   output logic                    credits_full_o,
   output logic                    credits_empty_o,
   output logic                    err_o
);

   localparam int idx_width_lp = ptr_width_lp - 1;

   `BP_BE_REPLAY_ENTRY_S(width_p);

   bp_be_replay_entry_s mem_q [els_p];
   bp_be_replay_entry_s head;

   logic [ptr_width_lp-1:0] wptr_q, wptr_d, rptr_q, rptr_d, cptr_q, cptr_d;
   logic                    err_q, err_d;
   logic                    full, ckpt_ok, yumi_eff, enq, credit_underflow;
   bp_be_rptr_op_e          rptr_op;

   assign head = mem_q[rptr_q[idx_width_lp-1:0]];

   // Full when write is a whole lap ahead of commit: only the wrap bit differs.
   assign full     = (wptr_q[ptr_width_lp-1] != cptr_q[ptr_width_lp-1])
                   && (wptr_q[idx_width_lp-1:0] == cptr_q[idx_width_lp-1:0]);
   assign ready_o  = !full;
   assign v_o      = (rptr_q != wptr_q) && !(head.uc_store && credits_full_o);
   assign data_o   = head.payload;
   assign count_o  = wptr_q - cptr_q;
   assign err_o    = err_q;

   // Roll and clear discard a same-cycle yumi; clear also discards the enqueue.
   assign ckpt_ok  = ckpt_v_i && (cptr_q != rptr_q);
   assign yumi_eff = yumi_i && v_o && !roll_v_i && !clr_v_i;
   assign enq      = v_i && ready_o && !clr_v_i;

   bp_be_replay_credit_counter #(
      .max_credits_p(max_credits_p)
   ) credits (
      .clk_i      (clk_i),
      .reset_n_i  (reset_n_i),
      .inc_i      (yumi_eff && head.uc_store),
      .dec_i      (credit_return_i),
      .full_o     (credits_full_o),
      .empty_o    (credits_empty_o),
      .underflow_o(credit_underflow)
   );

   // Pointer next-state: commit first, then clear > roll > issue; rewinds land on the new cptr.
   always_comb begin
      cptr_d  = cptr_q + ptr_width_lp'(ckpt_ok);
      wptr_d  = wptr_q;
      rptr_op = e_rptr_hold;
      if (clr_v_i) begin
         wptr_d  = cptr_d;
         rptr_op = e_rptr_rewind;
      end else begin
         if (enq)           wptr_d  = wptr_q + ptr_width_lp'(1);
         if (roll_v_i)      rptr_op = e_rptr_rewind;
         else if (yumi_eff) rptr_op = e_rptr_inc;
      end
      case (rptr_op)
         e_rptr_rewind: rptr_d = cptr_d;
         e_rptr_inc:    rptr_d = rptr_q + ptr_width_lp'(1);
         default:       rptr_d = rptr_q;
      endcase
      err_d = err_q || (ckpt_v_i && !ckpt_ok) || credit_underflow;
   end

   // Pointer and sticky-error registers.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         wptr_q <= '0;
         rptr_q <= '0;
         cptr_q <= '0;
         err_q  <= 1'b0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
         cptr_q <= cptr_d;
         err_q  <= err_d;
      end
   end

   // Entry storage, unreset; written only on an accepted enqueue.
   always_ff @(posedge clk_i) begin
      if (enq) mem_q[wptr_q[idx_width_lp-1:0]] <= '{uc_store: uc_store_i, payload: data_i};
   end

endmodule

// File: tb/tb_bp_be_dcache_replay_queue.sv
// tb/tb_bp_be_dcache_replay_queue.sv - scoreboard bench for the replay queue
module tb_bp_be_dcache_replay_queue;

   localparam int W    = 16;
   localparam int ELS  = 8;
   localparam int MAXC = 2;

   typedef struct packed {
      logic         uc;
      logic [W-1:0] d;
   } ent_t;

   logic         clk = 1'b0;
   logic         reset_n_i = 1'b0;
   logic [W-1:0] data_i = '0;
   logic         uc_store_i = 1'b0, v_i = 1'b0, yumi_i = 1'b0;
   logic         ckpt_v_i = 1'b0, roll_v_i = 1'b0, clr_v_i = 1'b0, credit_return_i = 1'b0;
   logic         ready_o, v_o, credits_full_o, credits_empty_o, err_o;
   logic [W-1:0] data_o;
   logic [3:0]   count_o;

   int   errors = 0;
   int   checks = 0;
   ent_t model[$];
   ent_t exp_q[$];
   int   cred = 0;
   bit   err_exp = 1'b0;
   bit   cons = 1'b0;

   bp_be_dcache_replay_queue #(
      .width_p(W), .els_p(ELS), .max_credits_p(MAXC)
   ) dut (
      .clk_i(clk), .reset_n_i(reset_n_i), .data_i(data_i), .uc_store_i(uc_store_i),
      .v_i(v_i), .ready_o(ready_o), .data_o(data_o), .v_o(v_o), .yumi_i(yumi_i),
      .ckpt_v_i(ckpt_v_i), .roll_v_i(roll_v_i), .clr_v_i(clr_v_i),
      .credit_return_i(credit_return_i), .count_o(count_o),
      .credits_full_o(credits_full_o), .credits_empty_o(credits_empty_o), .err_o(err_o)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: every accepted issue is compared against the scoreboard head.
   always @(negedge clk) begin
      if (reset_n_i && v_o && yumi_i) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL issue_unexpected: got %0h expected none", data_o);
         end else begin
            ent_t e;
            e = exp_q.pop_front();
            chk("issue_data", 32'(data_o), 32'(e.d));
         end
      end
   end

   task automatic chk_state();
      bit ev;
      ev = 1'b0;
      if (exp_q.size() > 0) ev = !(exp_q[0].uc && cred == MAXC);
      chk("ready_o", 32'(ready_o), 32'(model.size() < ELS));
      chk("count_o", 32'(count_o), 32'(model.size()));
      chk("v_o", 32'(v_o), 32'(ev));
      chk("credits_full_o", 32'(credits_full_o), 32'(cred == MAXC));
      chk("credits_empty_o", 32'(credits_empty_o), 32'(cred == 0));
      chk("err_o", 32'(err_o), 32'(err_exp));
   endtask

   // One clock with the currently driven inputs; the model advances at the edge.
   task automatic step();
      int issued_pre;
      bit full_pre, inc;
      issued_pre = model.size() - exp_q.size();
      full_pre   = (model.size() == ELS);
      yumi_i     = cons && v_o && !roll_v_i && !clr_v_i;
      inc        = yumi_i && exp_q.size() > 0 && exp_q[0].uc;
      @(posedge clk);
      if (ckpt_v_i) begin
         if (issued_pre > 0) void'(model.pop_front());
         else                err_exp = 1'b1;
      end
      if (credit_return_i && !inc && cred == 0) err_exp = 1'b1;
      else cred = cred + int'(inc) - int'(credit_return_i);
      if (clr_v_i) begin
         model.delete();
         exp_q.delete();
      end else begin
         if (roll_v_i) exp_q = model;
         if (v_i && !full_pre) begin
            model.push_back('{uc: uc_store_i, d: data_i});
            exp_q.push_back('{uc: uc_store_i, d: data_i});
         end
      end
      #1;
      v_i = 0; ckpt_v_i = 0; roll_v_i = 0; clr_v_i = 0; credit_return_i = 0; yumi_i = 0;
      chk_state();
   endtask

   task automatic enq(input logic uc, input logic [W-1:0] d);
      v_i = 1; uc_store_i = uc; data_i = d;
      step();
   endtask

   task automatic do_reset();
      reset_n_i = 0;
      v_i = 0; ckpt_v_i = 0; roll_v_i = 0; clr_v_i = 0; credit_return_i = 0; yumi_i = 0;
      #1;
      model.delete(); exp_q.delete(); cred = 0; err_exp = 0;
      chk("rst_ready_o", 32'(ready_o), 32'd1);
      chk("rst_v_o", 32'(v_o), 32'd0);
      chk("rst_count_o", 32'(count_o), 32'd0);
      chk("rst_credits_empty_o", 32'(credits_empty_o), 32'd1);
      chk("rst_credits_full_o", 32'(credits_full_o), 32'd0);
      chk("rst_err_o", 32'(err_o), 32'd0);
      @(posedge clk); #2;
      reset_n_i = 1;
      @(posedge clk); #1;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((model.size() > 0 || cred > 0) && n < 400) begin
         cons = 1;
         credit_return_i = (cred > 0);
         ckpt_v_i = (model.size() - exp_q.size()) > 0;
         step();
         n++;
      end
      cons = 0;
      if (n >= 400) begin
         checks++;
         errors++;
         $display("FAIL drain_timeout: got %0d entries left expected 0", model.size());
      end
      chk("drain_count_o", 32'(count_o), 32'd0);
      chk("drain_credits_empty_o", 32'(credits_empty_o), 32'd1);
   endtask

   initial begin
      int accepted;
      @(posedge clk); #1;
      do_reset();

      // Ordered issue, occupancy, then replay from the oldest uncommitted entry.
      cons = 0;
      enq(0, 16'h00A1); enq(0, 16'h00B2); enq(0, 16'h00C3);
      chk("t1_count3", 32'(count_o), 32'd3);
      chk("t1_head_A", 32'(data_o), 32'h00A1);
      cons = 1; step(); step(); step(); cons = 0;
      chk("t1_all_issued_v_o", 32'(v_o), 32'd0);
      roll_v_i = 1; step();
      chk("t1_roll_head_A", 32'(data_o), 32'h00A1);
      chk("t1_roll_v_o", 32'(v_o), 32'd1);
      drain();

      // Fill to depth, drop the extra enqueue, one commit reopens a slot.
      for (int i = 0; i < ELS; i++) enq(0, 16'h1000 + 16'(i));
      chk("t2_full_ready", 32'(ready_o), 32'd0);
      enq(0, 16'hDEAD);
      chk("t2_drop_count", 32'(count_o), 32'd8);
      cons = 1; step(); cons = 0;
      chk("t2_issue_ready", 32'(ready_o), 32'd0);
      ckpt_v_i = 1; step();
      chk("t2_ckpt_ready", 32'(ready_o), 32'd1);
      chk("t2_ckpt_count", 32'(count_o), 32'd7);
      drain();

      // Credit gating with two credits and three uncached stores.
      cons = 1;
      enq(1, 16'h5501); enq(1, 16'h5502); enq(1, 16'h5503);
      step();
      chk("t3_blocked_v_o", 32'(v_o), 32'd0);
      chk("t3_credits_full", 32'(credits_full_o), 32'd1);
      credit_return_i = 1; step();
      chk("t3_return_v_o", 32'(v_o), 32'd1);
      chk("t3_third_head", 32'(data_o), 32'h5503);
      step();
      chk("t3_third_issued_full", 32'(credits_full_o), 32'd1);
      cons = 0;
      drain();

      // Commit with roll, clear beats enqueue, commit with clear.
      enq(0, 16'h0D00); enq(0, 16'h0D01); enq(0, 16'h0D02);
      cons = 1; step(); step(); cons = 0;
      ckpt_v_i = 1; roll_v_i = 1; step();
      chk("t4_ckroll_count", 32'(count_o), 32'd2);
      chk("t4_ckroll_head", 32'(data_o), 32'h0D01);
      clr_v_i = 1; v_i = 1; data_i = 16'h0D03; uc_store_i = 0; step();
      chk("t4_clr_count", 32'(count_o), 32'd0);
      chk("t4_clr_v_o", 32'(v_o), 32'd0);
      enq(0, 16'h0E00); enq(0, 16'h0E01);
      cons = 1; step(); cons = 0;
      ckpt_v_i = 1; clr_v_i = 1; step();
      chk("t4_ckclr_count", 32'(count_o), 32'd0);
      enq(0, 16'h0F00);
      chk("t4_after_clr_head", 32'(data_o), 32'h0F00);
      drain();

      // Protocol errors: credit underflow, commit with nothing issued; both sticky.
      do_reset();
      credit_return_i = 1; step();
      chk("t5_underflow_err", 32'(err_o), 32'd1);
      chk("t5_underflow_empty", 32'(credits_empty_o), 32'd1);
      do_reset();
      enq(0, 16'h0777);
      ckpt_v_i = 1; step();
      chk("t5_ckpt_err", 32'(err_o), 32'd1);
      chk("t5_ckpt_count", 32'(count_o), 32'd1);
      step(); step(); step();
      chk("t5_err_sticky", 32'(err_o), 32'd1);

      // Reset mid-operation with five entries and two credits outstanding.
      do_reset();
      cons = 1;
      enq(1, 16'h6600); enq(1, 16'h6601); enq(0, 16'h6602); enq(0, 16'h6603); enq(0, 16'h6604);
      cons = 0;
      chk("t6_count5", 32'(count_o), 32'd5);
      chk("t6_credits2", 32'(credits_full_o), 32'd1);
      #2;
      do_reset();

      // Wraparound stress with random traffic, commits, rolls and returns.
      accepted = 0;
      for (int i = 0; i < 5000 && accepted < 100; i++) begin
         cons = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 2) != 0) begin
            v_i = 1;
            data_i = 16'($urandom);
            uc_store_i = ($urandom_range(0, 3) == 0);
            if (model.size() < ELS) accepted++;
         end
         credit_return_i = (cred > 0) && ($urandom_range(0, 2) == 0);
         ckpt_v_i = ((model.size() - exp_q.size()) > 0) && ($urandom_range(0, 1) == 1);
         roll_v_i = ($urandom_range(0, 15) == 0);
         step();
      end
      if (accepted < 100) begin
         checks++;
         errors++;
         $display("FAIL stress_timeout: got %0d packets expected 100", accepted);
      end
      drain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
